controlador_jogo: RTL and testbench

Game sequencer for the naval-battle board. Replaces the raw switch decode of game state with a registered FSM that walks power-off, map preparation, attack rounds and end of game. It samples each shot, classifies it (hit, miss or repeat), commands the attack-matrix write, and maintains lives and hit count. Its state flags drive the map mux, the LED-matrix enable, the display and the RGB status LED.

---
 rtl/controlador_jogo.sv | 198 +++++++++++++++++++
 tb/tb_controlador_jogo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_jogo.sv
`default_nettype none
// ============================================================================
// Module   : controlador_jogo
// Purpose  : Naval-battle game sequencer: power-off, map preparation, attack
//            rounds with shot classification, lives/hit bookkeeping, end game.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_jogo #(
  parameter int VIDAS      = 3,
  parameter int ALVOS      = 5,
  parameter int LED_CICLOS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       liga,
  input  logic       confirmar,
  input  logic [1:0] mapa_sel,
  input  logic [2:0] coordLinha,
  input  logic [2:0] coordColuna,
  input  logic       celula_navio,
  input  logic       celula_atacada,
  output logic       DESLIGADO,
  output logic       PREPARACAO,
  output logic       ATAQUE,
  output logic       FIM,
  output logic [1:0] mapa_id,
  output logic       carregar_mapa,
  output logic       limpar_ataque,
  output logic       grava_tiro,
  output logic [2:0] tiro_linha,
  output logic [2:0] tiro_coluna,
  output logic [1:0] vida,
  output logic [2:0] acertos,
  output logic       ligarMatriz,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B
);

  localparam logic [2:0] S_DESL    = 3'd0;
  localparam logic [2:0] S_PREP    = 3'd1;
  localparam logic [2:0] S_ATAQ    = 3'd2;
  localparam logic [2:0] S_AVAL    = 3'd3;
  localparam logic [2:0] S_MOSTRA  = 3'd4;
  localparam logic [2:0] S_VITORIA = 3'd5;
  localparam logic [2:0] S_DERROTA = 3'd6;

  localparam logic [1:0] c_RES_REPETIDO = 2'd0;
  localparam logic [1:0] c_RES_ACERTO   = 2'd1;
  localparam logic [1:0] c_RES_ERRO     = 2'd2;

  localparam int              c_CW         = (LED_CICLOS > 1) ? $clog2(LED_CICLOS) : 1;
  localparam logic [c_CW-1:0] c_MOSTRA_INI = c_CW'(LED_CICLOS - 1);
  localparam logic [1:0]      c_VIDAS      = 2'(VIDAS);
  localparam logic [2:0]      c_ALVOS      = 3'(ALVOS);

  logic [2:0]      r_estado;
  logic [2:0]      w_prox;
  logic [c_CW-1:0] r_cont;
  logic            r_navio;
  logic            r_atacada;
  logic            r_valido;
  logic [1:0]      r_resultado;

  logic w_coord_ok;
  logic w_limpa;
  logic w_carrega;
  logic w_captura;
  logic w_avalia;
  logic w_acerto;
  logic w_erro;
  logic w_reinicia;

  assign w_coord_ok = (coordLinha <= 3'd6) && (coordColuna <= 3'd4);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= S_DESL;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state logic; power switch off overrides everything
  always_comb begin
    w_prox = r_estado;
    if (!liga) begin
      w_prox = S_DESL;
    end else begin
      case (r_estado)
        S_DESL:   w_prox = S_PREP;
        S_PREP:   if (confirmar) w_prox = S_ATAQ;
        S_ATAQ:   if (confirmar) w_prox = S_AVAL;
        S_AVAL:   w_prox = S_MOSTRA;
        S_MOSTRA: begin
          if (r_cont == '0) begin
            if (acertos == c_ALVOS) begin
              w_prox = S_VITORIA;
            end else if (vida == 2'd0) begin
              w_prox = S_DERROTA;
            end else begin
              w_prox = S_ATAQ;
            end
          end
        end
        S_VITORIA, S_DERROTA: if (confirmar) w_prox = S_PREP;
        default:  w_prox = S_DESL;
      endcase
    end
  end

  // Output decode and datapath event enables
  always_comb begin
    DESLIGADO   = (r_estado == S_DESL);
    PREPARACAO  = (r_estado == S_PREP);
    ATAQUE      = (r_estado == S_ATAQ) || (r_estado == S_AVAL) || (r_estado == S_MOSTRA);
    FIM         = (r_estado == S_VITORIA) || (r_estado == S_DERROTA);
    ligarMatriz = (r_estado == S_PREP) || (r_estado == S_ATAQ) || (r_estado == S_AVAL) ||
                  (r_estado == S_MOSTRA) || (r_estado == S_VITORIA);

    LED_R = ((r_estado == S_MOSTRA) && (r_resultado == c_RES_ERRO)) || (r_estado == S_DERROTA);
    LED_G = ((r_estado == S_MOSTRA) && (r_resultado == c_RES_ACERTO)) || (r_estado == S_VITORIA);
    LED_B = (r_estado == S_MOSTRA) && (r_resultado == c_RES_REPETIDO);

    w_limpa    = liga && ((r_estado == S_DESL) ||
                 (((r_estado == S_VITORIA) || (r_estado == S_DERROTA)) && confirmar));
    w_carrega  = liga && (r_estado == S_PREP) && confirmar;
    w_captura  = liga && (r_estado == S_ATAQ) && confirmar;
    w_avalia   = liga && (r_estado == S_AVAL);
    w_acerto   = w_avalia && r_valido && !r_atacada && r_navio;
    w_erro     = w_avalia && r_valido && !r_atacada && !r_navio;
    w_reinicia = !liga ||
                 (((r_estado == S_VITORIA) || (r_estado == S_DERROTA)) && confirmar);
  end

  // Datapath: shot capture, result latch, display timer, counters, pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      mapa_id       <= 2'd0;
      carregar_mapa <= 1'b0;
      limpar_ataque <= 1'b0;
      grava_tiro    <= 1'b0;
      tiro_linha    <= 3'd0;
      tiro_coluna   <= 3'd0;
      vida          <= c_VIDAS;
      acertos       <= 3'd0;
      r_navio       <= 1'b0;
      r_atacada     <= 1'b0;
      r_valido      <= 1'b0;
      r_resultado   <= c_RES_REPETIDO;
      r_cont        <= '0;
    end else begin
      carregar_mapa <= w_carrega;
      limpar_ataque <= w_limpa;
      grava_tiro    <= w_acerto || w_erro;

      if (w_carrega) begin
        mapa_id <= mapa_sel;
      end

      if (w_captura) begin
        tiro_linha  <= coordLinha;
        tiro_coluna <= coordColuna;
        r_navio     <= celula_navio;
        r_atacada   <= celula_atacada;
        r_valido    <= w_coord_ok;
      end

      if (w_avalia) begin
        r_cont <= c_MOSTRA_INI;
        if (w_acerto) begin
          r_resultado <= c_RES_ACERTO;
        end else if (w_erro) begin
          r_resultado <= c_RES_ERRO;
        end else begin
          r_resultado <= c_RES_REPETIDO;
        end
      end else if ((r_estado == S_MOSTRA) && (r_cont != '0)) begin
        r_cont <= r_cont - c_CW'(1);
      end

      if (w_reinicia) begin
        vida    <= c_VIDAS;
        acertos <= 3'd0;
      end else begin
        if (w_acerto && (acertos != c_ALVOS)) begin
          acertos <= acertos + 3'd1;
        end
        if (w_erro && (vida != 2'd0)) begin
          vida <= vida - 2'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controlador_jogo.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_jogo
// Purpose  : Self-checking bench: game-rule model compared every cycle,
//            directed game scenarios, then randomized play.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_jogo;

  localparam int VIDAS = 3;
  localparam int ALVOS = 5;
  localparam int L     = 8;

  localparam int M_OFF = 0, M_PREP = 1, M_ATT = 2, M_EVAL = 3, M_SHOW = 4, M_WIN = 5, M_LOSE = 6;
  localparam int R_BLUE = 0, R_GREEN = 1, R_RED = 2;

  logic       clock = 1'b0;
  logic       reset, liga, confirmar;
  logic [1:0] mapa_sel;
  logic [2:0] coordLinha, coordColuna;
  logic       celula_navio, celula_atacada;
  logic       DESLIGADO, PREPARACAO, ATAQUE, FIM;
  logic [1:0] mapa_id;
  logic       carregar_mapa, limpar_ataque, grava_tiro;
  logic [2:0] tiro_linha, tiro_coluna;
  logic [1:0] vida;
  logic [2:0] acertos;
  logic       ligarMatriz, LED_R, LED_G, LED_B;

  controlador_jogo #(.VIDAS(VIDAS), .ALVOS(ALVOS), .LED_CICLOS(L)) dut (
    .clock(clock), .reset(reset), .liga(liga), .confirmar(confirmar),
    .mapa_sel(mapa_sel), .coordLinha(coordLinha), .coordColuna(coordColuna),
    .celula_navio(celula_navio), .celula_atacada(celula_atacada),
    .DESLIGADO(DESLIGADO), .PREPARACAO(PREPARACAO), .ATAQUE(ATAQUE), .FIM(FIM),
    .mapa_id(mapa_id), .carregar_mapa(carregar_mapa), .limpar_ataque(limpar_ataque),
    .grava_tiro(grava_tiro), .tiro_linha(tiro_linha), .tiro_coluna(tiro_coluna),
    .vida(vida), .acertos(acertos), .ligarMatriz(ligarMatriz),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Game-rule model: one update per clock edge from the sampled inputs.
  int m_mode = M_OFF, m_res = R_BLUE;
  int m_vida = VIDAS, m_ac = 0, m_mapa = 0, m_tl = 0, m_tc = 0;
  bit m_grava = 0, m_carrega = 0, m_limpa = 0;
  bit s_nav = 0, s_atk = 0, s_bad = 0;
  int edge_no = 0, show_end = 0;

  always @(posedge clock) begin
    edge_no   <= edge_no + 1;
    m_grava   <= 0;
    m_carrega <= 0;
    m_limpa   <= 0;
    if (reset) begin
      m_mode <= M_OFF; m_vida <= VIDAS; m_ac <= 0; m_mapa <= 0; m_tl <= 0; m_tc <= 0;
    end else if (!liga) begin
      m_mode <= M_OFF; m_vida <= VIDAS; m_ac <= 0;
    end else begin
      case (m_mode)
        M_OFF: begin m_mode <= M_PREP; m_limpa <= 1; end
        M_PREP: if (confirmar) begin
          m_mapa <= int'(mapa_sel); m_carrega <= 1; m_mode <= M_ATT;
        end
        M_ATT: if (confirmar) begin
          m_tl  <= int'(coordLinha); m_tc <= int'(coordColuna);
          s_nav <= celula_navio; s_atk <= celula_atacada;
          s_bad <= (coordLinha > 6) || (coordColuna > 4);
          m_mode <= M_EVAL;
        end
        M_EVAL: begin
          if (s_bad || s_atk) begin
            m_res <= R_BLUE;
          end else if (s_nav) begin
            m_res <= R_GREEN; m_grava <= 1;
            if (m_ac < ALVOS) m_ac <= m_ac + 1;
          end else begin
            m_res <= R_RED; m_grava <= 1;
            if (m_vida > 0) m_vida <= m_vida - 1;
          end
          show_end <= edge_no + L;
          m_mode   <= M_SHOW;
        end
        M_SHOW: if (edge_no == show_end) begin
          if (m_ac == ALVOS)     m_mode <= M_WIN;
          else if (m_vida == 0)  m_mode <= M_LOSE;
          else                   m_mode <= M_ATT;
        end
        default: if (confirmar) begin
          m_mode <= M_PREP; m_vida <= VIDAS; m_ac <= 0; m_limpa <= 1;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("DESLIGADO", DESLIGADO, m_mode == M_OFF);
      chk("PREPARACAO", PREPARACAO, m_mode == M_PREP);
      chk("ATAQUE", ATAQUE, m_mode == M_ATT || m_mode == M_EVAL || m_mode == M_SHOW);
      chk("FIM", FIM, m_mode == M_WIN || m_mode == M_LOSE);
      chk("ligarMatriz", ligarMatriz, m_mode != M_OFF && m_mode != M_LOSE);
      chk("LED_R", LED_R, (m_mode == M_SHOW && m_res == R_RED) || m_mode == M_LOSE);
      chk("LED_G", LED_G, (m_mode == M_SHOW && m_res == R_GREEN) || m_mode == M_WIN);
      chk("LED_B", LED_B, m_mode == M_SHOW && m_res == R_BLUE);
      chk("mapa_id", mapa_id, m_mapa);
      chk("carregar_mapa", carregar_mapa, m_carrega);
      chk("limpar_ataque", limpar_ataque, m_limpa);
      chk("grava_tiro", grava_tiro, m_grava);
      chk("tiro_linha", tiro_linha, m_tl);
      chk("tiro_coluna", tiro_coluna, m_tc);
      chk("vida", vida, m_vida);
      chk("acertos", acertos, m_ac);
    end
  end

  task automatic pulse_conf();
    confirmar = 1'b1;
    @(negedge clock);
    confirmar = 1'b0;
  endtask

  // Called just after a negedge; returns L+1 negedges after the confirm edge
  // (or one negedge after liga is dropped when drop_at >= 0).
  task automatic shot(input int r, input int c, input bit nav, input bit atk,
                      input bit extra, input int drop_at);
    coordLinha = 3'(r); coordColuna = 3'(c);
    celula_navio = nav; celula_atacada = atk;
    confirmar = 1'b1;
    @(negedge clock);
    confirmar      = extra;
    coordLinha     = 3'($urandom);
    coordColuna    = 3'($urandom);
    celula_navio   = 1'($urandom);
    celula_atacada = 1'($urandom);
    if (drop_at == 0) liga = 1'b0;
    for (int i = 1; i <= L + 1; i++) begin
      @(negedge clock);
      if (drop_at >= 0 && i == drop_at + 1) begin
        confirmar = 1'b0;
        return;
      end
      confirmar = extra && (i == 2);
      if (i == drop_at) liga = 1'b0;
    end
    confirmar = 1'b0;
  endtask

  initial begin
    reset = 1'b1; liga = 1'b0; confirmar = 1'b0; mapa_sel = 2'd0;
    coordLinha = 3'd0; coordColuna = 3'd0; celula_navio = 1'b0; celula_atacada = 1'b0;
    @(negedge clock);
    cmp_on = 1'b1;
    @(negedge clock);
    chk("rst_DESLIGADO", DESLIGADO, 1);
    chk("rst_vida", vida, 3);
    chk("rst_acertos", acertos, 0);
    chk("rst_leds", {LED_R, LED_G, LED_B}, 0);

    reset = 1'b0; liga = 1'b1;
    @(negedge clock);
    chk("up_PREPARACAO", PREPARACAO, 1);
    chk("up_limpar", limpar_ataque, 1);
    mapa_sel = 2'd2;
    pulse_conf();
    chk("map_carregar", carregar_mapa, 1);
    chk("map_id", mapa_id, 2);
    chk("map_ATAQUE", ATAQUE, 1);

    // Hit at (3,2), timed by hand
    coordLinha = 3'd3; coordColuna = 3'd2; celula_navio = 1'b1; celula_atacada = 1'b0;
    confirmar = 1'b1;
    @(negedge clock);
    confirmar = 1'b0; coordLinha = 3'd0; coordColuna = 3'd0; celula_navio = 1'b0;
    chk("hit_tiro_linha", tiro_linha, 3);
    chk("hit_tiro_coluna", tiro_coluna, 2);
    chk("hit_no_early_write", grava_tiro, 0);
    @(negedge clock);
    chk("hit_grava", grava_tiro, 1);
    chk("hit_acertos", acertos, 1);
    chk("hit_led_g", LED_G, 1);
    @(negedge clock);
    chk("hit_grava_once", grava_tiro, 0);
    repeat (L - 2) @(negedge clock);
    chk("hit_led_g_last", LED_G, 1);
    @(negedge clock);
    chk("hit_led_g_off", LED_G, 0);
    chk("hit_back_attack", ATAQUE, 1);

    shot(7, 1, 1'b1, 1'b0, 1'b0, -1);
    shot(2, 2, 1'b1, 1'b1, 1'b0, -1);
    chk("rep_vida", vida, 3);
    chk("rep_acertos", acertos, 1);

    for (int k = 0; k < 3; k++) shot(k, 4, 1'b0, 1'b0, 1'b0, -1);
    chk("lose_FIM", FIM, 1);
    chk("lose_led_r", LED_R, 1);
    chk("lose_matriz", ligarMatriz, 0);
    chk("lose_vida", vida, 0);

    pulse_conf();
    chk("restart_prep", PREPARACAO, 1);
    chk("restart_vida", vida, 3);
    chk("restart_acertos", acertos, 0);
    chk("restart_limpar", limpar_ataque, 1);
    mapa_sel = 2'd1;
    pulse_conf();

    for (int k = 0; k < ALVOS; k++) shot(6 - k, k, 1'b1, 1'b0, k == 1, -1);
    chk("win_FIM", FIM, 1);
    chk("win_led_g", LED_G, 1);
    chk("win_matriz", ligarMatriz, 1);
    chk("win_acertos", acertos, 5);
    pulse_conf();
    chk("win_restart_prep", PREPARACAO, 1);
    chk("win_restart_vida", vida, 3);
    chk("win_restart_limpar", limpar_ataque, 1);
    pulse_conf();

    shot(1, 1, 1'b0, 1'b0, 1'b0, 2);
    chk("drop_show_desl", DESLIGADO, 1);
    chk("drop_show_leds", {LED_R, LED_G, LED_B}, 0);
    liga = 1'b1;
    @(negedge clock);
    pulse_conf();
    shot(0, 0, 1'b1, 1'b0, 1'b0, 0);
    chk("drop_eval_desl", DESLIGADO, 1);
    chk("drop_eval_grava", grava_tiro, 0);
    chk("drop_eval_acertos", acertos, 0);
    liga = 1'b1;

    for (int k = 0; k < 4000; k++) begin
      reset          = ($urandom_range(0, 499) == 0);
      liga           = ($urandom_range(0, 99) != 0);
      confirmar      = ($urandom_range(0, 3) == 0);
      mapa_sel       = 2'($urandom);
      coordLinha     = 3'($urandom);
      coordColuna    = 3'($urandom);
      celula_navio   = ($urandom_range(0, 3) != 0);
      celula_atacada = ($urandom_range(0, 7) == 0);
      @(negedge clock);
    end
    reset = 1'b0; confirmar = 1'b0;
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
